// File: rtl/mix_pkg.sv
// Shared definitions for the MIX command units: word geometry, the
// serial-unit state encoding and F-field decoding.
package mix_pkg;

    localparam int BYTE_W_DEF = 6;
    localparam int BYTES_DEF  = 5;
    localparam int WORD_W_DEF = 1 + BYTE_W_DEF * BYTES_DEF;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADD,
        S_NEG,
        S_DONE
    } state_t;

    typedef struct packed {
        logic [2:0] l;
        logic [2:0] r;
        logic       valid;
    } fspec_t;

    // F = 8*L + R; a field is usable when L <= R <= bytes-per-word
    function automatic fspec_t decode_field(input logic [5:0] f, input int bytes);
        fspec_t d;
        d.l     = f[5:3];
        d.r     = f[2:0];
        d.valid = (d.l <= d.r) && (int'(d.r) <= bytes);
        return d;
    endfunction

endpackage

// File: rtl/mix_field_extract.sv
// Combinational MIX field selection: bytes L..R of a word, right-aligned and
// zero-filled, carrying the word's sign only when L = 0.
module mix_field_extract
    import mix_pkg::*;
#(
    parameter int  BYTE_W = BYTE_W_DEF,
    parameter int  BYTES  = BYTES_DEF,
    localparam int W      = 1 + BYTE_W * BYTES
) (
    input  logic [W-1:0] i_word,
    input  logic [5:0]   i_field,
    output logic [W-1:0] o_value,
    output logic         o_err
);

    localparam int MAG_W = BYTE_W * BYTES;

    fspec_t           w_fs;
    logic [2:0]       w_lo;
    logic [MAG_W-1:0] w_shifted;
    logic [MAG_W:0]   w_mask;
    int               w_shamt;
    int               w_nbits;

    always_comb begin
        w_fs    = decode_field(i_field, BYTES);
        // byte 0 is the sign, so magnitude bytes start at 1
        w_lo    = (w_fs.l == 3'd0) ? 3'd1 : w_fs.l;
        w_shamt = 0;
        w_nbits = 0;
        if (w_fs.valid) begin
            w_shamt = (BYTES - int'(w_fs.r)) * BYTE_W;
            if (w_fs.r >= w_lo)
                w_nbits = (int'(w_fs.r) - int'(w_lo) + 1) * BYTE_W;
        end
        w_shifted = i_word[MAG_W-1:0] >> w_shamt;
        w_mask    = ((MAG_W+1)'(1) << w_nbits) - (MAG_W+1)'(1);
        o_value   = {(w_fs.l == 3'd0) ? i_word[W-1] : 1'b0,
                     w_shifted & w_mask[MAG_W-1:0]};
        o_err     = !w_fs.valid;
    end

endmodule

// File: rtl/mix_addsub_serial.sv
// Byte-serial sign-magnitude ADD/SUB with F-field operand selection; one shared
// BYTE_W adder serves both the add pass and the optional negate pass.
module mix_addsub_serial
    import mix_pkg::*;
#(
    parameter int  BYTE_W = BYTE_W_DEF,
    parameter int  BYTES  = BYTES_DEF,
    localparam int W      = 1 + BYTE_W * BYTES
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_start,
    input  logic         i_sub,
    input  logic [5:0]   i_field,
    input  logic [W-1:0] i_in1,
    input  logic [W-1:0] i_in2,
    output logic [W-1:0] o_out,
    output logic         o_overflow,
    output logic         o_field_err,
    output logic         o_busy,
    output logic         o_stop
);

    localparam int             MAG_W = BYTE_W * BYTES;
    localparam int             CNT_W = $clog2(BYTES + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BYTES - 1);

    state_t           r_state, w_state_nxt;
    logic [MAG_W-1:0] r_a, r_b, r_res;
    logic [CNT_W-1:0] r_cnt;
    logic             r_carry, r_diff, r_sign_a;
    logic [W-1:0]     r_out;
    logic             r_ovf, r_ferr;

    logic [W-1:0]     w_ext;
    logic             w_ferr;
    logic [BYTE_W-1:0] w_op_x, w_op_y, w_sum;
    logic             w_cout, w_last;
    logic [MAG_W-1:0] w_res_full;

    mix_field_extract #(.BYTE_W(BYTE_W), .BYTES(BYTES)) u_extract (
        .i_word  (i_in2),
        .i_field (i_field),
        .o_value (w_ext),
        .o_err   (w_ferr)
    );

    // NEG reuses the adder as ~res + carry, walking the result register
    always_comb begin
        w_op_x     = (r_state == S_NEG) ? ~r_res[BYTE_W-1:0] : r_a[BYTE_W-1:0];
        w_op_y     = (r_state == S_NEG) ? '0
                   : (r_diff ? ~r_b[BYTE_W-1:0] : r_b[BYTE_W-1:0]);
        {w_cout, w_sum} = {1'b0, w_op_x} + {1'b0, w_op_y} + {{BYTE_W{1'b0}}, r_carry};
        w_res_full = {w_sum, r_res[MAG_W-1:BYTE_W]};
        w_last     = (r_cnt == LAST);
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (i_start) w_state_nxt = w_ferr ? S_DONE : S_ADD;
            S_ADD:  if (w_last)  w_state_nxt = (!r_diff || w_cout) ? S_DONE : S_NEG;
            S_NEG:  if (w_last)  w_state_nxt = S_DONE;
            S_DONE:              w_state_nxt = S_IDLE;
            default:             w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_a      <= '0;
            r_b      <= '0;
            r_res    <= '0;
            r_cnt    <= '0;
            r_carry  <= 1'b0;
            r_diff   <= 1'b0;
            r_sign_a <= 1'b0;
            r_out    <= '0;
            r_ovf    <= 1'b0;
            r_ferr   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (i_start) begin
                    r_a      <= i_in1[MAG_W-1:0];
                    r_b      <= w_ext[MAG_W-1:0];
                    r_sign_a <= i_in1[W-1];
                    r_diff   <= i_in1[W-1] ^ w_ext[W-1] ^ i_sub;
                    r_carry  <= i_in1[W-1] ^ w_ext[W-1] ^ i_sub;
                    r_res    <= '0;
                    r_cnt    <= '0;
                    r_out    <= w_ferr ? i_in1 : '0;
                    r_ovf    <= 1'b0;
                    r_ferr   <= w_ferr;
                end
                S_ADD: begin
                    r_a     <= r_a >> BYTE_W;
                    r_b     <= r_b >> BYTE_W;
                    r_res   <= w_res_full;
                    r_carry <= w_cout;
                    r_cnt   <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_cnt <= '0;
                        // carry set on a subtract means |A| >= |B|: no negate needed
                        if (!r_diff || w_cout) begin
                            r_out <= {r_sign_a, w_res_full};
                            r_ovf <= !r_diff && w_cout;
                        end else begin
                            r_carry <= 1'b1;
                        end
                    end
                end
                S_NEG: begin
                    r_res   <= w_res_full;
                    r_carry <= w_cout;
                    r_cnt   <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_cnt <= '0;
                        r_out <= {(w_res_full == '0) ? r_sign_a : !r_sign_a, w_res_full};
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_out       = r_out;
    assign o_overflow  = r_ovf;
    assign o_field_err = r_ferr;
    assign o_busy      = (r_state != S_IDLE);
    assign o_stop      = (r_state == S_DONE);

endmodule

// File: tb/tb_mix_addsub_serial.sv
// Scoreboard bench for mix_addsub_serial: directed cases plus random commands
// checked against an integer-arithmetic model of MIX ADD/SUB.
module tb_mix_addsub_serial;

    localparam int BW = 6;
    localparam int NB = 5;
    localparam int W  = 1 + BW * NB;

    logic         clk = 1'b0;
    logic         rst, start, sub;
    logic [5:0]   field;
    logic [W-1:0] in1, in2, out;
    logic         ovf, ferr, busy, stop;

    typedef struct {
        logic [W-1:0] out;
        logic         ovf;
        logic         ferr;
        int           lat;
        int           t0;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    mix_addsub_serial #(.BYTE_W(BW), .BYTES(NB)) dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_start     (start),
        .i_sub       (sub),
        .i_field     (field),
        .i_in1       (in1),
        .i_in2       (in2),
        .o_out       (out),
        .o_overflow  (ovf),
        .o_field_err (ferr),
        .o_busy      (busy),
        .o_stop      (stop)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic s, input logic [5:0] f,
                                   input logic [W-1:0] a, input logic [W-1:0] v);
        exp_t   e;
        int     l, r;
        longint ma, mb, va, vb, sum, m;
        logic   sa, sb;
        l = int'(f) / 8;
        r = int'(f) % 8;
        e.t0 = 0;
        if (l > r || r > NB) begin
            e.out = a; e.ovf = 1'b0; e.ferr = 1'b1; e.lat = 1;
            return e;
        end
        ma = longint'(a[W-2:0]);
        sa = a[W-1];
        mb = 0;
        for (int i = (l == 0 ? 1 : l); i <= r; i++)
            mb = mb * (1 << BW) + (longint'(v >> ((NB - i) * BW)) & ((1 << BW) - 1));
        sb = ((l == 0) ? v[W-1] : 1'b0) ^ s;
        va  = sa ? -ma : ma;
        vb  = sb ? -mb : mb;
        sum = va + vb;
        m   = (sum < 0) ? -sum : sum;
        e.ovf = (m >= (longint'(1) << (W - 1)));
        if (e.ovf) m = m - (longint'(1) << (W - 1));
        e.out  = {(m == 0) ? sa : (sum < 0), m[W-2:0]};
        e.ferr = 1'b0;
        e.lat  = (sa != sb && mb > ma) ? 2 * NB + 1 : NB + 1;
        return e;
    endfunction

    // issue one command; optionally poke a second start while it is busy
    task automatic issue(input logic s, input logic [5:0] f,
                         input logic [W-1:0] a, input logic [W-1:0] v, input bit poke);
        exp_t e;
        int   n;
        @(negedge clk);
        start = 1'b1; sub = s; field = f; in1 = a; in2 = v;
        e = model(s, f, a, v);
        e.t0 = cyc + 1;
        q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        if (poke && !stop) begin
            @(negedge clk);
            start = 1'b1; sub = ~s; field = 6'd5; in1 = ~a; in2 = ~v;
            @(negedge clk);
            start = 1'b0;
        end
        n = 0;
        while (!stop) begin
            if (n == 40) begin
                chk("stop_timeout", 0, 1);
                break;
            end
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        logic [2:0] l, r;
        rst = 1'b1; start = 1'b0; sub = 1'b0; field = '0; in1 = '0; in2 = '0;

        fork
            forever begin
                @(negedge clk);
                if (stop) begin
                    if (q.size() == 0) begin
                        chk("unexpected_stop", 1, 0);
                    end else begin
                        exp_t e;
                        e = q.pop_front();
                        chk("out", longint'(out), longint'(e.out));
                        chk("overflow", longint'(ovf), longint'(e.ovf));
                        chk("field_err", longint'(ferr), longint'(e.ferr));
                        chk("latency", cyc - e.t0 + 1, e.lat);
                    end
                end
            end
        join_none

        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_out", longint'(out), 0);
        chk("rst_busy", longint'(busy), 0);
        chk("rst_stop", longint'(stop), 0);

        issue(1'b0, 6'd5, 31'd100, 31'd23, 1'b0);
        issue(1'b1, 6'd5, 31'd100, 31'd123, 1'b0);
        issue(1'b0, 6'd5, 31'h3FFF_FFFF, 31'd1, 1'b0);
        issue(1'b0, 6'd37, 31'd0, {1'b1, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5}, 1'b0);
        issue(1'b1, 6'd5, {1'b1, 30'd7}, {1'b1, 30'd7}, 1'b0);
        issue(1'b0, 6'd26, {1'b1, 30'd999}, 31'd5, 1'b0);
        issue(1'b0, 6'd0, {1'b1, 30'd42}, {1'b1, 30'd77}, 1'b0);
        issue(1'b1, 6'd13, 31'd50, 31'h2345_6789, 1'b1);

        // abort mid-command: no stop, outputs cleared
        @(negedge clk);
        start = 1'b1; sub = 1'b1; field = 6'd5; in1 = 31'd3; in2 = 31'd900;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_out", longint'(out), 0);
        chk("abort_busy", longint'(busy), 0);
        chk("abort_stop", longint'(stop), 0);
        repeat (15) @(negedge clk);

        // start and reset together: command dropped
        start = 1'b1; rst = 1'b1;
        @(negedge clk);
        start = 1'b0; rst = 1'b0;
        chk("rst_start_busy", longint'(busy), 0);
        repeat (3) @(negedge clk);

        issue(1'b0, 6'd5, {1'b1, 30'd1234}, 31'd1234, 1'b0);

        for (int k = 0; k < 40; k++) begin
            logic [5:0]   f;
            logic [W-1:0] a, v;
            l = 3'($urandom_range(0, NB));
            r = 3'($urandom_range(int'(l), NB));
            f = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(0, 63)) : {l, r};
            a = W'($urandom);
            v = ($urandom_range(0, 7) == 0) ? a : W'($urandom);
            issue(1'($urandom), f, a, v, ($urandom_range(0, 5) == 0));
        end

        for (int n = 0; n < 40 && q.size() != 0; n++) @(negedge clk);
        chk("queue_drained", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mix_addsub_serial.md
# mix_addsub_serial

Byte-serial sign-magnitude adder/subtractor for the MIX datapath: the parametrised successor to the single-cycle `add` unit.
- Executes ADD and SUB with full MIX field specification (L:R) applied to the memory operand.
- Processes one byte per cycle with a shared BYTE_W-bit adder and an optional negate pass.
- Trades latency for area on wide words.
- Sits beside the other command units and keeps the `start`/`stop` handshake used by the control sequencer.

## Interface
- BYTE_W, 6: bits per MIX byte.
- BYTES, 5: bytes per word; word width W = 1 + BYTE_W*BYTES (sign in MSB).
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle command strobe; sampled only in IDLE.
- sub  in  1  0 = ADD, 1 = SUB; sampled with start.
- field  in  6  MIX F-field, 8*L+R; sampled with start.
- in1  in  W  rA contents; sampled with start.
- in2  in  W  memory word V; sampled with start.
- out  out  W  result word, registered; reset 0.
- overflow  out  1  magnitude carry out; reset 0.
- field_err  out  1  invalid F-field; reset 0.
- busy  out  1  high from the cycle after start to stop inclusive; reset 0.
- stop  out  1  one-cycle done pulse; reset 0.

## Operation
- States: IDLE, ADD, NEG, DONE.
- IDLE, start=1:
  - Latch A = in1.
  - Extract B from in2: bytes L..R right-aligned, zero-filled above. Byte 1 is the most significant byte.
  - Sign of B = in2 sign if L=0, else +.
  - Invert the sign of B if sub=1.
  - Clear the byte counter and the carry.
  - Go to ADD.
- Invalid field (L>R or R>BYTES): go straight to DONE with out = in1, overflow = 0, field_err = 1.
- ADD, one byte per cycle, least significant byte first, BYTES cycles.
  - Same signs: byte = a + b + carry.
  - Different signs: byte = a + ~b + carry, initial carry 1 (two's-complement subtract).
- End of ADD:
  - Same signs: overflow = final carry; result sign = sign of A.
  - Different signs with final carry = 1 (|A| >= |B|): result sign = sign of A; go to DONE.
  - Different signs with final carry = 0 (|B| > |A|): go to NEG.
- NEG: byte-serial two's-complement negate of the magnitude, BYTES cycles, then flip the result sign. Overflow is never set on this path.
- Zero magnitude result: sign = sign of A (MIX rule: "sign of rA unchanged"). This overrides any sign computed above.
- DONE: assert stop for one cycle, then return to IDLE.
- out, overflow and field_err hold until the next accepted start. All three clear at that start.
- start while busy: ignored, no queuing.

## Timing
- Start accepted at edge t.
- ADD occupies cycles t+1 .. t+BYTES.
- stop is high in cycle t+BYTES+1 without negate, or t+2*BYTES+1 with negate (6 or 11 cycles at defaults).
- Invalid field: stop in cycle t+1.
- out is valid no later than the cycle stop is high.
- reset at any point (mid-ADD or mid-NEG):
  - Next cycle: IDLE, all outputs 0.
  - No stop pulse for the aborted command.
- start and reset high together: reset wins; the command is dropped.
- start is accepted again in the cycle after stop. Back-to-back throughput is one command per latency+1 cycles.

## Structure
- Package `mix_pkg`:
  - BYTE_W and BYTES defaults.
  - State enum.
  - Word-width localparam.
  - Function decoding the F-field into L and R plus a validity bit.
- Sub-module `mix_field_extract`: combinational. Inputs: word and field. Outputs: signed field value and err. It is reused later by LDA/CMP units.
- Top-level block contents: FSM, byte counter, shift registers for A, B and the result, carry flop.

## Test plan
- ADD, field 5 (0:5), in1 = +100, in2 = +23 -> out = +123, overflow 0, stop at t+6.
- SUB, field 5, in1 = +100, in2 = +123 -> out = -23, overflow 0, stop at t+11 (negate pass).
- ADD, field 5, in1 = +(2^30-1), in2 = +1 -> out magnitude 0, sign +, overflow 1.
- ADD, field 37 (4:5), in1 = +0, in2 = - bytes (1,2,3,4,5) -> out = +261 (4*64+5), sign + because L>0.
- SUB, field 5, in1 = -7, in2 = -7 -> out = -0 (sign of rA kept), overflow 0.
- Invalid field 26 (3:2) -> field_err = 1, out = in1, stop at t+1.
- Reset asserted at t+3 of a command -> no stop pulse, outputs 0.
- start pulsed while busy -> ignored; the first result is unaffected.
